// File: rtl/apb_timer_bus_arbiter_pkg.sv
// Shared definitions for the two-requester APB master in front of timer_counter_8bit.
package apb_timer_bus_arbiter_pkg;

    // APB master phase encoding, also exposed on the debug port
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } apb_state_e;

    // Timer register map
    localparam logic [2:0] TDR_ADDR = 3'b010;  // timer data / reload register
    localparam logic [2:0] TCR_ADDR = 3'b011;  // timer control register

    // Timer control register bit positions
    localparam int TCR_LOAD_BIT   = 7;  // load TDR into the counter
    localparam int TCR_UPDN_BIT   = 5;  // 1 = count down, 0 = count up
    localparam int TCR_EN_BIT     = 4;  // counter enable
    localparam int TCR_CKS_LSB    = 0;  // clock select field [1:0]
    localparam int TCR_CKS_WIDTH  = 2;

endpackage

// File: rtl/apb_timer_bus_arbiter_rr_arbiter_2.sv
// Two-way round-robin arbiter: on a tie the requester that did not win last time wins.
module rr_arbiter_2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant,
    output logic       valid
);

    // Pick the winner purely combinationally; the caller owns last_grant
    always_comb begin
        valid = |req;
        grant = 1'b0;
        case (req)
            2'b01:   grant = 1'b0;
            2'b10:   grant = 1'b1;
            2'b11:   grant = ~last_grant;
            default: grant = 1'b0;
        endcase
    end

endmodule

// File: rtl/apb_timer_bus_arbiter.sv
// Two-requester APB master sharing one timer APB slave port.
// Handshake: a requester holds req_i with stable command fields until it is granted;
// fields are captured at grant only, and ack_i pulses for exactly one cycle with
// rdata_i / err_i valid in that same cycle. Dropping req after grant does not cancel.
module apb_timer_bus_arbiter
    import apb_timer_bus_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int TIMEOUT    = 16
) (
    input  logic                  pclk,
    input  logic                  preset_n,
    input  logic                  req_0,
    input  logic                  write_0,
    input  logic [ADDR_WIDTH-1:0] addr_0,
    input  logic [DATA_WIDTH-1:0] wdata_0,
    output logic                  ack_0,
    output logic [DATA_WIDTH-1:0] rdata_0,
    output logic                  err_0,
    input  logic                  req_1,
    input  logic                  write_1,
    input  logic [ADDR_WIDTH-1:0] addr_1,
    input  logic [DATA_WIDTH-1:0] wdata_1,
    output logic                  ack_1,
    output logic [DATA_WIDTH-1:0] rdata_1,
    output logic                  err_1,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic [DATA_WIDTH-1:0] pwdata,
    input  logic [DATA_WIDTH-1:0] prdata,
    input  logic                  pready,
    input  logic                  pslverr,
    output apb_state_e            dbg_state
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    apb_state_e            state_q, state_d;
    logic                  psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic                  gnt_q, gnt_d, last_grant_q, last_grant_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  ack_0_q, ack_0_d, ack_1_q, ack_1_d;
    logic                  err_0_q, err_0_d, err_1_q, err_1_d;
    logic [DATA_WIDTH-1:0] rdata_0_q, rdata_0_d, rdata_1_q, rdata_1_d;
    logic                  arb_grant, arb_valid;
    logic                  finish;
    logic [DATA_WIDTH-1:0] fin_rdata;
    logic                  fin_err;

    rr_arbiter_2 u_arb (
        .req        ({req_1, req_0}),
        .last_grant (last_grant_q),
        .grant      (arb_grant),
        .valid      (arb_valid)
    );

    // Next-state, APB phase outputs, timeout counting and response routing
    always_comb begin
        state_d      = state_q;
        psel_d       = psel_q;
        penable_d    = penable_q;
        pwrite_d     = pwrite_q;
        paddr_d      = paddr_q;
        pwdata_d     = pwdata_q;
        gnt_d        = gnt_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        ack_0_d      = 1'b0;
        ack_1_d      = 1'b0;
        err_0_d      = err_0_q;
        err_1_d      = err_1_q;
        rdata_0_d    = rdata_0_q;
        rdata_1_d    = rdata_1_q;
        finish       = 1'b0;
        fin_rdata    = '0;
        fin_err      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                psel_d    = 1'b0;
                penable_d = 1'b0;
                if (arb_valid) begin
                    gnt_d        = arb_grant;
                    last_grant_d = arb_grant;
                    pwrite_d     = arb_grant ? write_1 : write_0;
                    paddr_d      = arb_grant ? addr_1  : addr_0;
                    pwdata_d     = arb_grant ? wdata_1 : wdata_0;
                    psel_d       = 1'b1;
                    state_d      = ST_SETUP;
                end
            end
            ST_SETUP: begin
                penable_d = 1'b1;
                state_d   = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (pready) begin
                    finish    = 1'b1;
                    fin_rdata = pwrite_q ? '0 : prdata;
                    fin_err   = pslverr;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    // Last permitted wait cycle expired: abort with an error
                    finish    = 1'b1;
                    fin_rdata = '0;
                    fin_err   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                psel_d    = 1'b0;
                penable_d = 1'b0;
                cnt_d     = '0;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (finish) begin
            state_d   = ST_DONE;
            psel_d    = 1'b0;
            penable_d = 1'b0;
            cnt_d     = '0;
            if (gnt_q) begin
                ack_1_d   = 1'b1;
                rdata_1_d = fin_rdata;
                err_1_d   = fin_err;
            end else begin
                ack_0_d   = 1'b1;
                rdata_0_d = fin_rdata;
                err_0_d   = fin_err;
            end
        end
    end

    // Register every state element; reset aborts any transfer in flight without an ack
    always_ff @(posedge pclk) begin
        if (!preset_n) begin
            state_q      <= ST_IDLE;
            psel_q       <= 1'b0;
            penable_q    <= 1'b0;
            pwrite_q     <= 1'b0;
            paddr_q      <= '0;
            pwdata_q     <= '0;
            gnt_q        <= 1'b0;
            last_grant_q <= 1'b1;
            cnt_q        <= '0;
            ack_0_q      <= 1'b0;
            ack_1_q      <= 1'b0;
            err_0_q      <= 1'b0;
            err_1_q      <= 1'b0;
            rdata_0_q    <= '0;
            rdata_1_q    <= '0;
        end else begin
            state_q      <= state_d;
            psel_q       <= psel_d;
            penable_q    <= penable_d;
            pwrite_q     <= pwrite_d;
            paddr_q      <= paddr_d;
            pwdata_q     <= pwdata_d;
            gnt_q        <= gnt_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            ack_0_q      <= ack_0_d;
            ack_1_q      <= ack_1_d;
            err_0_q      <= err_0_d;
            err_1_q      <= err_1_d;
            rdata_0_q    <= rdata_0_d;
            rdata_1_q    <= rdata_1_d;
        end
    end

    assign psel      = psel_q;
    assign penable   = penable_q;
    assign pwrite    = pwrite_q;
    assign paddr     = paddr_q;
    assign pwdata    = pwdata_q;
    assign ack_0     = ack_0_q;
    assign ack_1     = ack_1_q;
    assign err_0     = err_0_q;
    assign err_1     = err_1_q;
    assign rdata_0   = rdata_0_q;
    assign rdata_1   = rdata_1_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_apb_timer_bus_arbiter.sv
// Directed bench for apb_timer_bus_arbiter; the APB slave is driven by hand.
module tb_apb_timer_bus_arbiter;
    import apb_timer_bus_arbiter_pkg::*;

    logic       pclk = 1'b0;
    logic       preset_n;
    logic       req_0, write_0, req_1, write_1;
    logic [2:0] addr_0, addr_1;
    logic [7:0] wdata_0, wdata_1;
    logic       ack_0, err_0, ack_1, err_1;
    logic [7:0] rdata_0, rdata_1;
    logic       psel, penable, pwrite;
    logic [2:0] paddr;
    logic [7:0] pwdata, prdata;
    logic       pready, pslverr;
    apb_state_e dbg_state;

    int errors = 0;
    int checks = 0;
    int n;

    apb_timer_bus_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .TIMEOUT(16)) dut (
        .pclk(pclk), .preset_n(preset_n),
        .req_0(req_0), .write_0(write_0), .addr_0(addr_0), .wdata_0(wdata_0),
        .ack_0(ack_0), .rdata_0(rdata_0), .err_0(err_0),
        .req_1(req_1), .write_1(write_1), .addr_1(addr_1), .wdata_1(wdata_1),
        .ack_1(ack_1), .rdata_1(rdata_1), .err_1(err_1),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
        .dbg_state(dbg_state)
    );

    // Clock
    always #5 pclk = ~pclk;

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it
    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    initial begin
        preset_n = 1'b0;
        req_0 = 0; write_0 = 0; addr_0 = 0; wdata_0 = 0;
        req_1 = 0; write_1 = 0; addr_1 = 0; wdata_1 = 0;
        prdata = 8'h00; pready = 1'b1; pslverr = 1'b0;

        // ---------------- reset ----------------
        tick(); tick();
        preset_n = 1'b1;
        check("rst_psel", psel, 0);
        check("rst_penable", penable, 0);
        check("rst_pwrite", pwrite, 0);
        check("rst_paddr", paddr, 0);
        check("rst_pwdata", pwdata, 0);
        check("rst_ack_0", ack_0, 0);
        check("rst_ack_1", ack_1, 0);
        check("rst_rdata_0", rdata_0, 0);
        check("rst_rdata_1", rdata_1, 0);
        check("rst_err_0", err_0, 0);
        check("rst_err_1", err_1, 0);
        check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        tick();
        check("idle_psel", psel, 0);

        // ---------------- single write, zero wait ----------------
        req_0 = 1; write_0 = 1; addr_0 = TDR_ADDR; wdata_0 = 8'h5A;
        tick();
        check("wr_setup_psel", psel, 1);
        check("wr_setup_penable", penable, 0);
        check("wr_setup_paddr", paddr, 3'b010);
        check("wr_setup_pwdata", pwdata, 8'h5A);
        check("wr_setup_pwrite", pwrite, 1);
        req_0 = 0; write_0 = 0; addr_0 = 0; wdata_0 = 0;
        tick();
        check("wr_access_psel", psel, 1);
        check("wr_access_penable", penable, 1);
        check("wr_access_paddr", paddr, 3'b010);
        check("wr_access_pwdata", pwdata, 8'h5A);
        tick();
        check("wr_done_ack_0", ack_0, 1);
        check("wr_done_err_0", err_0, 0);
        check("wr_done_rdata_0", rdata_0, 0);
        check("wr_done_ack_1", ack_1, 0);
        check("wr_done_psel", psel, 0);
        check("wr_done_penable", penable, 0);
        tick();
        check("wr_after_ack_0", ack_0, 0);
        check("wr_after_state", 32'(dbg_state), 32'(ST_IDLE));

        // ---------------- read from requester 1 with 3 wait states ----------------
        req_1 = 1; write_1 = 0; addr_1 = TCR_ADDR; pready = 0; prdata = 8'hA2;
        tick();
        check("rd_setup_psel", psel, 1);
        check("rd_setup_penable", penable, 0);
        check("rd_setup_pwrite", pwrite, 0);
        req_1 = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rd_access_penable", penable, 1);
            check("rd_access_psel", psel, 1);
            check("rd_access_paddr", paddr, 3'b011);
            if (i == 3) pready = 1;
        end
        tick();
        check("rd_done_ack_1", ack_1, 1);
        check("rd_done_rdata_1", rdata_1, 8'hA2);
        check("rd_done_err_1", err_1, 0);
        check("rd_done_ack_0", ack_0, 0);
        tick();
        check("rd_after_ack_1", ack_1, 0);
        prdata = 8'h00;

        // ---------------- contention: both held, grants alternate 0,1,0,1 ----------------
        req_0 = 1; write_0 = 1; addr_0 = 3'b010; wdata_0 = 8'h11;
        req_1 = 1; write_1 = 1; addr_1 = 3'b100; wdata_1 = 8'h22;
        for (int k = 0; k < 4; k++) begin
            logic exp_owner;
            exp_owner = logic'(k % 2);
            tick();
            check("ct_setup_pwdata", pwdata, exp_owner ? 8'h22 : 8'h11);
            check("ct_setup_paddr", paddr, exp_owner ? 3'b100 : 3'b010);
            tick();
            check("ct_access_penable", penable, 1);
            tick();
            check("ct_done_ack_0", ack_0, !exp_owner);
            check("ct_done_ack_1", ack_1, exp_owner);
            if (k == 3) begin
                req_0 = 0; req_1 = 0;
            end
            tick();
            check("ct_idle_ack_0", ack_0, 0);
            check("ct_idle_ack_1", ack_1, 0);
        end
        tick();
        check("ct_quiet_psel", psel, 0);

        // ---------------- slave error ----------------
        req_0 = 1; write_0 = 1; addr_0 = 3'b011; wdata_0 = 8'h77; pslverr = 1;
        tick();
        req_0 = 0;
        tick();
        tick();
        check("se_ack_0", ack_0, 1);
        check("se_err_0", err_0, 1);
        check("se_rdata_0", rdata_0, 0);
        tick();
        pslverr = 0;
        check("se_after_ack_0", ack_0, 0);

        // ---------------- timeout: pready stuck low ----------------
        req_0 = 1; write_0 = 0; addr_0 = 3'b010; pready = 0; prdata = 8'hFF;
        tick();
        check("to_setup_psel", psel, 1);
        req_0 = 0;
        n = 0;
        tick();
        while (penable === 1'b1 && n < 40) begin
            n++;
            tick();
        end
        check("to_access_cycles", n, 16);
        check("to_ack_0", ack_0, 1);
        check("to_err_0", err_0, 1);
        check("to_rdata_0", rdata_0, 0);
        check("to_done_psel", psel, 0);
        tick();
        check("to_after_psel", psel, 0);
        check("to_after_ack_0", ack_0, 0);
        pready = 1; prdata = 8'h00;

        // ---------------- reset mid-ACCESS ----------------
        req_0 = 1; write_0 = 0; addr_0 = 3'b011; pready = 0;
        tick();
        req_0 = 0;
        tick();
        tick();
        check("mr_in_access", penable, 1);
        preset_n = 0;
        req_0 = 1; write_0 = 1; addr_0 = 3'b010; wdata_0 = 8'hC3;
        req_1 = 1; write_1 = 1; addr_1 = 3'b101; wdata_1 = 8'h3C;
        pready = 1;
        tick();
        check("mr_psel", psel, 0);
        check("mr_penable", penable, 0);
        check("mr_ack_0", ack_0, 0);
        check("mr_ack_1", ack_1, 0);
        tick();
        check("mr_hold_ack_0", ack_0, 0);
        preset_n = 1;
        tick();
        check("mr_first_pwdata", pwdata, 8'hC3);
        req_0 = 0;
        tick();
        tick();
        check("mr_first_ack_0", ack_0, 1);
        check("mr_first_ack_1", ack_1, 0);
        tick();
        tick();
        check("mr_second_pwdata", pwdata, 8'h3C);
        check("mr_second_paddr", paddr, 3'b101);
        req_1 = 0;
        tick();
        tick();
        check("mr_second_ack_1", ack_1, 1);
        check("mr_second_ack_0", ack_0, 0);
        tick();
        check("mr_end_state", 32'(dbg_state), 32'(ST_IDLE));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
